mmio_bus_arbiter: RTL and testbench

//   Shares the single MMIO data bus (memAddress/memWriteData/memWrite/byteMask/

---
 rtl/mmio_bus_arbiter_if.sv | 42 ++++
 rtl/mmio_bus_arbiter.sv | 108 ++++++++++
 tb/tb_mmio_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_bus_arbiter_if.sv
// Signal bundle shared by the two MMIO masters, the arbiter and the slave data bus.
// The arbiter uses the slave modport; the master modport is the environment's view.
interface mmio_bus_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_we;
  logic [3:0]  m0_mask;
  logic        m0_ready;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_we;
  logic [3:0]  m1_mask;
  logic        m1_ready;
  logic [31:0] m1_rdata;

  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic [3:0]  byteMask;
  logic [31:0] memReadData;
  logic        busy;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_we, m0_mask,
    input  m1_req, m1_addr, m1_wdata, m1_we, m1_mask,
    input  memReadData,
    output m0_ready, m0_rdata, m1_ready, m1_rdata,
    output memAddress, memWriteData, memWrite, byteMask, busy
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_we, m0_mask,
    output m1_req, m1_addr, m1_wdata, m1_we, m1_mask,
    output memReadData,
    input  m0_ready, m0_rdata, m1_ready, m1_rdata,
    input  memAddress, memWriteData, memWrite, byteMask, busy
  );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// Round-robin arbiter sharing one MMIO data bus between two masters, sequencing
// each transaction through a fixed slave read latency and a one-cycle ready pulse.
module mmio_bus_arbiter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  mmio_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY - 1);

  state_t      state;
  state_t      state_next;
  logic [2:0]  wait_cnt;
  logic        last_grant;
  logic        sel;
  logic        grant_valid;
  logic        grant_sel;

  // On a tie the master that was not served last wins; last_grant resets to 1 so m0 wins first.
  assign grant_valid = bus.m0_req | bus.m1_req;
  assign grant_sel   = bus.m1_req & (~bus.m0_req | ~last_grant);

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ADDR;
      ADDR:    state_next = WAIT;
      WAIT:    if (wait_cnt == 3'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Master inputs are only looked at in IDLE; everything after is driven from the latched copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.memAddress   <= 32'd0;
      bus.memWriteData <= 32'd0;
      bus.memWrite     <= 1'b0;
      bus.byteMask     <= 4'd0;
      bus.m0_ready     <= 1'b0;
      bus.m1_ready     <= 1'b0;
      bus.m0_rdata     <= 32'd0;
      bus.m1_rdata     <= 32'd0;
      last_grant       <= 1'b1;
      sel              <= 1'b0;
      wait_cnt         <= 3'd0;
    end else begin
      bus.m0_ready <= 1'b0;
      bus.m1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            sel              <= grant_sel;
            last_grant       <= grant_sel;
            bus.memAddress   <= grant_sel ? bus.m1_addr  : bus.m0_addr;
            bus.memWriteData <= grant_sel ? bus.m1_wdata : bus.m0_wdata;
            bus.memWrite     <= grant_sel ? bus.m1_we    : bus.m0_we;
            bus.byteMask     <= grant_sel ? bus.m1_mask  : bus.m0_mask;
          end
        end
        ADDR: begin
          bus.memWrite <= 1'b0;
          wait_cnt     <= WAIT_INIT;
        end
        WAIT: begin
          // Final wait edge: slave data is valid now, so capture it and raise ready for RESP.
          if (wait_cnt == 3'd0) begin
            bus.byteMask <= 4'd0;
            if (sel) begin
              bus.m1_rdata <= bus.memReadData;
              bus.m1_ready <= 1'b1;
            end else begin
              bus.m0_rdata <= bus.memReadData;
              bus.m0_ready <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Randomized bench for mmio_bus_arbiter: a transaction-level model predicts every bus and
// master output each cycle from grant order, latency offsets and a synthetic slave.
module tb_mmio_bus_arbiter;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cyc = 32'd0;
  int          total = 0;
  int          bad = 0;

  logic        mreq   [2];
  logic [31:0] maddr  [2];
  logic [31:0] mwdata [2];
  logic        mwe    [2];
  logic [3:0]  mmask  [2];

  bit          rand_mode;
  bit          rel_pending;
  bit          plan_req   [2];
  bit          hold       [2];
  logic [31:0] plan_addr  [2];
  logic [31:0] plan_wdata [2];
  logic        plan_we    [2];
  logic [3:0]  plan_mask  [2];
  int          rdy_cnt    [2];

  // Reference model: one active transaction, ph = cycles since the granting IDLE cycle.
  bit          act;
  int          ph;
  int          msel;
  int          last_g;
  logic [31:0] m_addr, m_wdata;
  logic        m_we;
  logic [3:0]  m_mask;
  logic [31:0] e_addr, e_wdata, pend;
  logic [31:0] e_rdata [2];

  mmio_bus_arbiter_if bus ();

  mmio_bus_arbiter #(.READ_LATENCY(LAT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.m0_req   = mreq[0];
  assign bus.m0_addr  = maddr[0];
  assign bus.m0_wdata = mwdata[0];
  assign bus.m0_we    = mwe[0];
  assign bus.m0_mask  = mmask[0];
  assign bus.m1_req   = mreq[1];
  assign bus.m1_addr  = maddr[1];
  assign bus.m1_wdata = mwdata[1];
  assign bus.m1_we    = mwe[1];
  assign bus.m1_mask  = mmask[1];

  function automatic logic [31:0] slave_fn(input logic [31:0] a, input logic [31:0] c);
    return (a * 32'h9E37_79B1) ^ {c[15:0], c[31:16]};
  endfunction

  // Registered slave whose data depends on both address and cycle, so capture timing matters.
  always @(posedge clk) begin
    cyc             <= cyc + 32'd1;
    bus.memReadData <= slave_fn(bus.memAddress, cyc);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    act        = 1'b0;
    ph         = 0;
    last_g     = 1;
    e_addr     = 32'd0;
    e_wdata    = 32'd0;
    e_rdata[0] = 32'd0;
    e_rdata[1] = 32'd0;
  endfunction

  task automatic newRandom(input int x);
    mreq[x]   = 1'b1;
    maddr[x]  = $urandom;
    mwdata[x] = $urandom;
    mwe[x]    = 1'($urandom_range(0, 1));
    mmask[x]  = 4'($urandom_range(0, 15));
  endtask

  task automatic setPlan(input int x, input bit rq, input logic [31:0] a, input logic [31:0] d,
                         input logic we, input logic [3:0] mk, input bit hd);
    plan_req[x]   = rq;
    plan_addr[x]  = a;
    plan_wdata[x] = d;
    plan_we[x]    = we;
    plan_mask[x]  = mk;
    hold[x]       = hd;
  endtask

  task automatic applyStimulus();
    for (int x = 0; x < 2; x++) begin
      bit done_x;
      bit busy_x;
      done_x = act && ph == LAT + 2 && msel == x;
      busy_x = act && msel == x && ph >= 1 && ph < LAT + 2;
      if (rand_mode) begin
        if (!mreq[x]) begin
          if ($urandom_range(0, 2) == 0) newRandom(x);
        end else if (done_x) begin
          if ($urandom_range(0, 1) == 1) newRandom(x);
          else mreq[x] = 1'b0;
        end else if (busy_x && $urandom_range(0, 5) == 0) begin
          newRandom(x);
          mreq[x] = 1'($urandom_range(0, 1));
        end
      end else begin
        if (done_x && !hold[x]) plan_req[x] = 1'b0;
        mreq[x]   = plan_req[x];
        maddr[x]  = plan_addr[x];
        mwdata[x] = plan_wdata[x];
        mwe[x]    = plan_we[x];
        mmask[x]  = plan_mask[x];
      end
    end
  endtask

  task automatic step();
    logic [31:0] x_busy, x_we, x_mask, x_rdy0, x_rdy1;
    int g;
    @(negedge clk);
    if (reset_n == 1'b0) model_reset();
    if (rel_pending) begin
      reset_n     = 1'b1;
      rel_pending = 1'b0;
    end
    if (act) begin
      ph++;
      if (ph == LAT + 3) act = 1'b0;
    end
    if (act && ph == 1) begin
      e_addr  = m_addr;
      e_wdata = m_wdata;
    end
    if (act && ph == LAT) pend = slave_fn(m_addr, cyc);
    if (act && ph == LAT + 2) e_rdata[msel] = pend;

    x_busy = 32'(act && ph >= 1);
    x_we   = 32'(act && ph == 1 && m_we);
    x_mask = (act && ph >= 1 && ph <= LAT + 1) ? 32'(m_mask) : 32'd0;
    x_rdy0 = 32'(act && ph == LAT + 2 && msel == 0);
    x_rdy1 = 32'(act && ph == LAT + 2 && msel == 1);
    checkOutput("busy",         32'(bus.busy),     x_busy);
    checkOutput("memWrite",     32'(bus.memWrite), x_we);
    checkOutput("byteMask",     32'(bus.byteMask), x_mask);
    checkOutput("memAddress",   bus.memAddress,    e_addr);
    checkOutput("memWriteData", bus.memWriteData,  e_wdata);
    checkOutput("m0_ready",     32'(bus.m0_ready), x_rdy0);
    checkOutput("m1_ready",     32'(bus.m1_ready), x_rdy1);
    checkOutput("m0_rdata",     bus.m0_rdata,      e_rdata[0]);
    checkOutput("m1_rdata",     bus.m1_rdata,      e_rdata[1]);
    if (bus.m0_ready === 1'b1) rdy_cnt[0]++;
    if (bus.m1_ready === 1'b1) rdy_cnt[1]++;

    applyStimulus();

    // Arbitration for this IDLE cycle, from the round-robin rule.
    if (!act && reset_n) begin
      g = -1;
      if (mreq[0] && mreq[1]) g = 1 - last_g;
      else if (mreq[0]) g = 0;
      else if (mreq[1]) g = 1;
      if (g >= 0) begin
        msel    = g;
        last_g  = g;
        m_addr  = maddr[g];
        m_wdata = mwdata[g];
        m_we    = mwe[g];
        m_mask  = mmask[g];
        act     = 1'b1;
        ph      = 0;
      end
    end
  endtask

  task automatic midReset();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_busy",     32'(bus.busy),     32'd0);
    checkOutput("rst_memWrite", 32'(bus.memWrite), 32'd0);
    checkOutput("rst_byteMask", 32'(bus.byteMask), 32'd0);
    checkOutput("rst_m0_ready", 32'(bus.m0_ready), 32'd0);
    checkOutput("rst_m1_ready", 32'(bus.m1_ready), 32'd0);
    model_reset();
    rand_mode = 1'b0;
    setPlan(0, 1'b1, $urandom, $urandom, 1'b0, 4'hF, 1'b1);
    setPlan(1, 1'b1, $urandom, $urandom, 1'b1, 4'h3, 1'b1);
    repeat (2) step();
    rel_pending = 1'b1;
    step();
    rdy_cnt[0] = 0;
    rdy_cnt[1] = 0;
    repeat (LAT + 2) step();
    checkOutput("rst_first_m0", 32'(rdy_cnt[0]), 32'd1);
    checkOutput("rst_first_m1", 32'(rdy_cnt[1]), 32'd0);
    setPlan(0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    setPlan(1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    repeat (LAT + 8) step();
    rand_mode = 1'b1;
  endtask

  initial begin
    bit did_wait_rst;
    bit did_addr_rst;
    did_wait_rst = 1'b0;
    did_addr_rst = 1'b0;
    for (int x = 0; x < 2; x++) begin
      mreq[x] = 1'b0; maddr[x] = 32'd0; mwdata[x] = 32'd0; mwe[x] = 1'b0; mmask[x] = 4'd0;
      setPlan(x, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0);
      rdy_cnt[x] = 0;
    end
    rand_mode = 1'b0;
    model_reset();
    repeat (2) step();
    rel_pending = 1'b1;
    step();
    repeat (2) step();

    // m0 read then m1 write to the top of the address map
    setPlan(0, 1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0, 4'hF, 1'b0);
    repeat (LAT + 6) step();
    setPlan(1, 1'b1, 32'hFFFF_FFF0, 32'h1500_0000, 1'b1, 4'b1000, 1'b0);
    repeat (LAT + 6) step();

    // both masters held: four transactions alternate 0,1,0,1
    setPlan(0, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 1'b0, 4'hF, 1'b1);
    setPlan(1, 1'b1, 32'h0000_2000, 32'h5A5A_5A5A, 1'b1, 4'h6, 1'b1);
    step();
    rdy_cnt[0] = 0;
    rdy_cnt[1] = 0;
    repeat (4 * (LAT + 3)) step();
    checkOutput("rr_m0_count", 32'(rdy_cnt[0]), 32'd2);
    checkOutput("rr_m1_count", 32'(rdy_cnt[1]), 32'd2);
    setPlan(0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    setPlan(1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    repeat (LAT + 8) step();

    // m0 alone, request held: one ready every LAT+3 cycles
    setPlan(0, 1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0, 4'hC, 1'b1);
    step();
    rdy_cnt[0] = 0;
    repeat (3 * (LAT + 3)) step();
    checkOutput("solo_m0_count", 32'(rdy_cnt[0]), 32'd3);
    setPlan(0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    repeat (LAT + 8) step();

    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      step();
      if (!did_wait_rst && i > 300 && act && ph >= 2 && ph <= LAT + 1) begin
        did_wait_rst = 1'b1;
        midReset();
      end else if (!did_addr_rst && i > 800 && act && ph == 1) begin
        did_addr_rst = 1'b1;
        midReset();
      end
    end
    rand_mode = 1'b0;
    setPlan(0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    setPlan(1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    repeat (LAT + 8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
